// File: rtl/mips_processor.sv
// mips_processor: self-contained 5-stage pipelined MIPS32 integer core.
// IF/ID/EX/MEM/WB pipeline with internal instruction ROM, data RAM and a
// 32x32 register file. Branches and jumps resolve in EX. RAW hazards are
// handled by forwarding plus a load-use stall, or by stalling alone,
// depending on FORWARDING_EN.
module mips_processor #(
  parameter int    IMEM_WORDS = 1024,
  parameter int    DMEM_WORDS = 1024,
  parameter string IMEM_FILE  = "program.hex",
  parameter string DMEM_FILE  = ""
) (
  input  logic CLK,
  input  logic RESET,
  input  logic FORWARDING_EN
);

  localparam int IMEM_AW = $clog2(IMEM_WORDS);
  localparam int DMEM_AW = $clog2(DMEM_WORDS);

  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_SLT,
    ALU_NOR
  } alu_op_e;

  // All-zero control word is a bubble: no register, memory or PC effect.
  typedef struct packed {
    logic    reg_write;
    logic    mem_read;
    logic    mem_write;
    logic    alu_src_imm;
    logic    branch_eq;
    logic    branch_ne;
    logic    jump;
    alu_op_e alu_op;
  } ctrl_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
  } ifid_t;

  typedef struct packed {
    ctrl_t       ctrl;
    logic [31:0] pc4;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic [31:0] imm;
    logic [25:0] jidx;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  dest;
  } idex_t;

  typedef struct packed {
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] alu_y;
    logic [31:0] store_data;
    logic [4:0]  dest;
  } exmem_t;

  typedef struct packed {
    logic        reg_write;
    logic [31:0] wdata;
    logic [4:0]  dest;
  } memwb_t;

  // Storage
  logic [31:0] imem [IMEM_WORDS];
  logic [31:0] dmem [DMEM_WORDS];
  logic [31:0] rf   [32];

  // Pipeline state
  logic [31:0] pc;
  ifid_t       ifid;
  idex_t       idex;
  exmem_t      exmem;
  memwb_t      memwb;

  // Memories start all-zero at time 0.
  initial begin
    for (int i = 0; i < IMEM_WORDS; i++) imem[i] = '0;
    for (int i = 0; i < DMEM_WORDS; i++) dmem[i] = '0;
  end

  // ---------------------------------------------------------------- IF
  logic [31:0]        pc_plus4;
  logic [IMEM_AW-1:0] imem_idx;
  logic [31:0]        if_instr;

  assign pc_plus4 = pc + 32'd4;
  assign imem_idx = IMEM_AW'(pc[31:2] % 30'(IMEM_WORDS));
  assign if_instr = imem[imem_idx];

  // ---------------------------------------------------------------- ID
  logic [5:0]  id_opcode;
  logic [5:0]  id_funct;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic [4:0]  id_rd;
  logic [15:0] id_imm16;
  ctrl_t       id_ctrl;
  logic        id_uses_rs;
  logic        id_uses_rt;
  logic        id_zero_ext;
  logic [4:0]  id_dest;
  logic [31:0] id_imm;
  logic [31:0] id_rs_val;
  logic [31:0] id_rt_val;
  logic        id_hit_idex;
  logic        id_hit_exmem;
  logic        id_stall;
  idex_t       id_next;
  logic        unused_shamt;

  assign id_opcode    = ifid.instr[31:26];
  assign id_rs        = ifid.instr[25:21];
  assign id_rt        = ifid.instr[20:16];
  assign id_rd        = ifid.instr[15:11];
  assign id_funct     = ifid.instr[5:0];
  assign id_imm16     = ifid.instr[15:0];
  assign unused_shamt = ^ifid.instr[10:6];

  // Decode: anything not recognised keeps the all-zero (NOP) control word.
  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    id_ctrl     = '0;
    id_uses_rs  = 1'b0;
    id_uses_rt  = 1'b0;
    id_zero_ext = 1'b0;
    id_dest     = id_rt;
    case (id_opcode)
      6'h00: begin
        id_dest = id_rd;
        case (id_funct)
          6'h20: id_ctrl.alu_op = ALU_ADD;
          6'h22: id_ctrl.alu_op = ALU_SUB;
          6'h24: id_ctrl.alu_op = ALU_AND;
          6'h25: id_ctrl.alu_op = ALU_OR;
          6'h2A: id_ctrl.alu_op = ALU_SLT;
          6'h27: id_ctrl.alu_op = ALU_NOR;
          default: ;
        endcase
        if (id_funct inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h27}) begin
          id_ctrl.reg_write = 1'b1;
          id_uses_rs        = 1'b1;
          id_uses_rt        = 1'b1;
        end
      end
      6'h08, 6'h0C, 6'h0D, 6'h0A: begin
        id_ctrl.reg_write   = 1'b1;
        id_ctrl.alu_src_imm = 1'b1;
        id_uses_rs          = 1'b1;
        case (id_opcode)
          6'h0C:   begin id_ctrl.alu_op = ALU_AND; id_zero_ext = 1'b1; end
          6'h0D:   begin id_ctrl.alu_op = ALU_OR;  id_zero_ext = 1'b1; end
          6'h0A:   id_ctrl.alu_op = ALU_SLT;
          default: id_ctrl.alu_op = ALU_ADD;
        endcase
      end
      6'h23: begin
        id_ctrl.reg_write   = 1'b1;
        id_ctrl.mem_read    = 1'b1;
        id_ctrl.alu_src_imm = 1'b1;
        id_uses_rs          = 1'b1;
      end
      6'h2B: begin
        id_ctrl.mem_write   = 1'b1;
        id_ctrl.alu_src_imm = 1'b1;
        id_uses_rs          = 1'b1;
        id_uses_rt          = 1'b1;
      end
      6'h04: begin
        id_ctrl.branch_eq = 1'b1;
        id_uses_rs        = 1'b1;
        id_uses_rt        = 1'b1;
      end
      6'h05: begin
        id_ctrl.branch_ne = 1'b1;
        id_uses_rs        = 1'b1;
        id_uses_rt        = 1'b1;
      end
      6'h02:   id_ctrl.jump = 1'b1;
      default: ;
    endcase
    // A write to r0 is dropped at decode, so no later stage ever sees r0
    // as a producer (no hazard match, no forwarding, no regfile write).
    if (id_dest == 5'd0) id_ctrl.reg_write = 1'b0;
  end

  assign id_imm = id_zero_ext ? {16'h0000, id_imm16} : {{16{id_imm16[15]}}, id_imm16};

  // Register read with write-through from the instruction retiring in WB.
  assign id_rs_val = (id_rs == 5'd0) ? '0 :
                     (memwb.reg_write && memwb.dest == id_rs) ? memwb.wdata : rf[id_rs];
  assign id_rt_val = (id_rt == 5'd0) ? '0 :
                     (memwb.reg_write && memwb.dest == id_rt) ? memwb.wdata : rf[id_rt];

  assign id_hit_idex  = idex.ctrl.reg_write &&
                        ((id_uses_rs && id_rs == idex.dest) || (id_uses_rt && id_rt == idex.dest));
  assign id_hit_exmem = exmem.reg_write &&
                        ((id_uses_rs && id_rs == exmem.dest) || (id_uses_rt && id_rt == exmem.dest));

  // Stall decision: load-use only with forwarding, any pending producer without.
  always_comb begin
    id_stall = 1'b0;
    if (FORWARDING_EN) id_stall = id_hit_idex && idex.ctrl.mem_read;
    else               id_stall = id_hit_idex || id_hit_exmem;
  end

  // Assemble the ID/EX payload for the decoded instruction.
  always_comb begin
    id_next        = '0;
    id_next.ctrl   = id_ctrl;
    id_next.pc4    = ifid.pc4;
    id_next.rs_val = id_rs_val;
    id_next.rt_val = id_rt_val;
    id_next.imm    = id_imm;
    id_next.jidx   = ifid.instr[25:0];
    id_next.rs     = id_rs;
    id_next.rt     = id_rt;
    id_next.dest   = id_dest;
  end

  // ---------------------------------------------------------------- EX
  logic [31:0] ex_a;
  logic [31:0] ex_b;
  logic [31:0] alu_b;
  logic [31:0] ex_y;
  logic        ex_taken;
  logic [31:0] ex_target;
  exmem_t      ex_next;

  // Operand forwarding: EX/MEM has priority over MEM/WB.
  always_comb begin
    ex_a = idex.rs_val;
    ex_b = idex.rt_val;
    if (FORWARDING_EN) begin
      if (exmem.reg_write && exmem.dest == idex.rs)      ex_a = exmem.alu_y;
      else if (memwb.reg_write && memwb.dest == idex.rs) ex_a = memwb.wdata;
      if (exmem.reg_write && exmem.dest == idex.rt)      ex_b = exmem.alu_y;
      else if (memwb.reg_write && memwb.dest == idex.rt) ex_b = memwb.wdata;
    end
  end

  // ALU
  always_comb begin
    alu_b = idex.ctrl.alu_src_imm ? idex.imm : ex_b;
    case (idex.ctrl.alu_op)
      ALU_SUB: ex_y = ex_a - alu_b;
      ALU_AND: ex_y = ex_a & alu_b;
      ALU_OR:  ex_y = ex_a | alu_b;
      ALU_SLT: ex_y = {31'd0, $signed(ex_a) < $signed(alu_b)};
      ALU_NOR: ex_y = ~(ex_a | alu_b);
      default: ex_y = ex_a + alu_b;
    endcase
  end

  assign ex_taken  = idex.ctrl.jump ||
                     (idex.ctrl.branch_eq && ex_a == ex_b) ||
                     (idex.ctrl.branch_ne && ex_a != ex_b);
  assign ex_target = idex.ctrl.jump ? {idex.pc4[31:28], idex.jidx, 2'b00}
                                    : idex.pc4 + {idex.imm[29:0], 2'b00};

  // Assemble the EX/MEM payload.
  always_comb begin
    ex_next            = '0;
    ex_next.reg_write  = idex.ctrl.reg_write;
    ex_next.mem_read   = idex.ctrl.mem_read;
    ex_next.mem_write  = idex.ctrl.mem_write;
    ex_next.alu_y      = ex_y;
    ex_next.store_data = ex_b;
    ex_next.dest       = idex.dest;
  end

  // ---------------------------------------------------------------- MEM
  logic [DMEM_AW-1:0] dmem_idx;
  logic [31:0]        dmem_rdata;
  memwb_t             mem_next;

  assign dmem_idx   = DMEM_AW'(exmem.alu_y[31:2] % 30'(DMEM_WORDS));
  assign dmem_rdata = dmem[dmem_idx];

  // Data memory write port.
  // NOTE: memory arrays carry no reset so they map onto RAM macros; data
  // memory contents survive RESET by design.
  always_ff @(posedge CLK) begin
    if (exmem.mem_write) dmem[dmem_idx] <= exmem.store_data;
  end

  // Assemble the MEM/WB payload.
  always_comb begin
    mem_next           = '0;
    mem_next.reg_write = exmem.reg_write;
    mem_next.wdata     = exmem.mem_read ? dmem_rdata : exmem.alu_y;
    mem_next.dest      = exmem.dest;
  end

  // ---------------------------------------------------------------- state
  // Fetch side: advance, hold on stall, or redirect and flush on a taken branch.
  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      pc   <= '0;
      ifid <= '0;
    end else if (ex_taken) begin
      pc   <= ex_target;
      ifid <= '0;
    end else if (!id_stall) begin
      pc         <= pc_plus4;
      ifid.instr <= if_instr;
      ifid.pc4   <= pc_plus4;
    end
  end

  // ID/EX: decoded instruction, or a bubble on stall or flush.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET)                    idex <= '0;
    else if (ex_taken || id_stall) idex <= '0;
    else                           idex <= id_next;
  end

  // EX/MEM and MEM/WB always advance.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      exmem <= '0;
      memwb <= '0;
    end else begin
      exmem <= ex_next;
      memwb <= mem_next;
    end
  end

  // Register file write port; cleared by reset.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else if (memwb.reg_write) begin
      rf[memwb.dest] <= memwb.wdata;
    end
  end

endmodule

// File: tb/tb_mips_processor.sv
// tb_mips_processor: directed programs plus random programs checked against
// an instruction-level reference interpreter, in both hazard modes.
module tb_mips_processor;

  localparam logic [31:0] SELF_LOOP = 32'h1000FFFF;  // BEQ r0,r0,-1

  logic CLK           = 1'b0;
  logic RESET         = 1'b0;
  logic FORWARDING_EN = 1'b1;

  int n_cmp = 0;
  int n_err = 0;
  int cycle = 0;

  logic [31:0] prog     [$];
  logic [31:0] ref_rf   [32];
  logic [31:0] ref_dmem [1024];
  logic [5:0]  fn_tab   [7] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h27, 6'h21};

  mips_processor #(
    .IMEM_WORDS(1024),
    .DMEM_WORDS(1024),
    .IMEM_FILE (""),
    .DMEM_FILE ("")
  ) dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .FORWARDING_EN(FORWARDING_EN)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] enc_r(input logic [5:0] fn, input logic [4:0] rd,
                                        input logic [4:0] rs, input logic [4:0] rt);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rt,
                                        input logic [4:0] rs, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic int widx(input logic [31:0] addr);
    return int'(addr[31:2] % 30'd1024);
  endfunction

  task automatic wr(input logic [4:0] r, input logic [31:0] v);
    if (r != 5'd0) ref_rf[r] = v;
  endtask

  // Architectural interpreter: one instruction per step, no pipeline notion.
  task automatic model_run();
    logic [31:0] pc, ins, a, b, imm_s, imm_z;
    int idx;
    for (int i = 0; i < 32; i++) ref_rf[i] = '0;
    pc = '0;
    for (int step = 0; step < 4096; step++) begin
      idx = widx(pc);
      ins = (idx < prog.size()) ? prog[idx] : 32'h0;
      if (ins == SELF_LOOP) break;
      a     = ref_rf[ins[25:21]];
      b     = ref_rf[ins[20:16]];
      imm_s = {{16{ins[15]}}, ins[15:0]};
      imm_z = {16'h0000, ins[15:0]};
      pc    = pc + 32'd4;
      case (ins[31:26])
        6'h00: case (ins[5:0])
          6'h20: wr(ins[15:11], a + b);
          6'h22: wr(ins[15:11], a - b);
          6'h24: wr(ins[15:11], a & b);
          6'h25: wr(ins[15:11], a | b);
          6'h2A: wr(ins[15:11], ($signed(a) < $signed(b)) ? 32'd1 : 32'd0);
          6'h27: wr(ins[15:11], ~(a | b));
          default: ;
        endcase
        6'h08: wr(ins[20:16], a + imm_s);
        6'h0C: wr(ins[20:16], a & imm_z);
        6'h0D: wr(ins[20:16], a | imm_z);
        6'h0A: wr(ins[20:16], ($signed(a) < $signed(imm_s)) ? 32'd1 : 32'd0);
        6'h23: wr(ins[20:16], ref_dmem[widx(a + imm_s)]);
        6'h2B: ref_dmem[widx(a + imm_s)] = b;
        6'h04: if (a == b) pc = pc + (imm_s << 2);
        6'h05: if (a != b) pc = pc + (imm_s << 2);
        6'h02: pc = {pc[31:28], ins[25:0], 2'b00};
        default: ;
      endcase
    end
  endtask

  // Program image is written only while the core is held in reset.
  task automatic load_program();
    RESET = 1'b0;
    #1;
    for (int i = 0; i < 1024; i++) dut.imem[i] = (i < prog.size()) ? prog[i] : 32'h0;
    model_run();
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
    cycle++;
  endtask

  task automatic start_run(input logic fwd);
    RESET         = 1'b0;
    FORWARDING_EN = fwd;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RESET = 1'b1;
    cycle = 0;
  endtask

  task automatic run_cycles(input int n);
    repeat (n) tick();
  endtask

  task automatic wait_reg(input int r, input logic [31:0] val, input int budget, output int at);
    at = -1;
    while (cycle < budget && dut.rf[r] !== val) tick();
    if (dut.rf[r] === val) at = cycle;
  endtask

  task automatic prog_a();
    prog.delete();
    prog.push_back(enc_i(6'h08, 5'd1, 5'd0, 16'd5));
    prog.push_back(enc_i(6'h08, 5'd2, 5'd0, 16'd7));
    prog.push_back(enc_r(6'h20, 5'd3, 5'd1, 5'd2));
    prog.push_back(enc_i(6'h2B, 5'd3, 5'd0, 16'd8));
    prog.push_back(enc_i(6'h23, 5'd4, 5'd0, 16'd8));
    prog.push_back(enc_r(6'h20, 5'd5, 5'd4, 5'd4));
    prog.push_back(SELF_LOOP);
  endtask

  task automatic gen_random(input int len);
    int          kind, k;
    logic [4:0]  ra, rb, rc;
    logic [15:0] imm;
    logic [5:0]  op;
    prog.delete();
    for (int i = 0; i < len; i++) begin
      kind = $urandom_range(0, 11);
      ra   = 5'($urandom_range(0, 7));
      rb   = 5'($urandom_range(0, 7));
      rc   = 5'($urandom_range(0, 7));
      imm  = 16'($urandom);
      case (kind)
        0, 1, 2, 3, 4: prog.push_back(enc_r(fn_tab[$urandom_range(0, 5)], ra, rb, rc));
        5, 6: begin
          case ($urandom_range(0, 3))
            0:       op = 6'h08;
            1:       op = 6'h0C;
            2:       op = 6'h0D;
            default: op = 6'h0A;
          endcase
          prog.push_back(enc_i(op, ra, rb, imm));
        end
        7:  prog.push_back(enc_i(6'h23, ra, rb, imm));
        8:  prog.push_back(enc_i(6'h2B, ra, rb, imm));
        9:  prog.push_back(($urandom_range(0, 1) == 0) ? enc_r(fn_tab[6], ra, rb, rc)
                                                     : enc_i(6'h3F, ra, rb, imm));
        default: begin
          k = $urandom_range(0, 2);
          if (i + 1 + k > len) k = len - i - 1;
          case ($urandom_range(0, 2))
            0:       prog.push_back(enc_i(6'h04, rb, ra, 16'(k)));
            1:       prog.push_back(enc_i(6'h05, rb, ra, 16'(k)));
            default: prog.push_back({6'h02, 26'(i + 1 + k)});
          endcase
        end
      endcase
    end
    prog.push_back(SELF_LOOP);
  endtask

  task automatic compare_all(input string tag);
    for (int r = 0; r < 32; r++) check($sformatf("%s_r%0d", tag, r), dut.rf[r], ref_rf[r]);
    for (int w = 0; w < 1024; w++) check($sformatf("%s_dmem%0d", tag, w), dut.dmem[w], ref_dmem[w]);
  endtask

  initial begin
    int t3_f1, t5_f1, t3_f0, t5_f0;
    for (int i = 0; i < 1024; i++) ref_dmem[i] = '0;

    // Reset state
    repeat (2) @(posedge CLK);
    #1;
    check("reset_pc", dut.pc, 32'h0);
    for (int r = 0; r < 32; r += 5) check($sformatf("reset_r%0d", r), dut.rf[r], 32'h0);

    // Program A with forwarding: back-to-back ALU, store, load-use
    prog_a();
    load_program();
    start_run(1'b1);
    wait_reg(3, 32'd12, 60, t3_f1);
    wait_reg(5, 32'd24, 60, t5_f1);
    run_cycles(30);
    check("a_f1_r3", dut.rf[3], 32'd12);
    check("a_f1_r4", dut.rf[4], 32'd12);
    check("a_f1_r5", dut.rf[5], 32'd24);
    check("a_f1_dmem2", dut.dmem[2], 32'd12);
    check("a_f1_loaduse_gap", 32'(t5_f1 - t3_f1), 32'd4);

    // Program A stall-only
    load_program();
    start_run(1'b0);
    wait_reg(3, 32'd12, 60, t3_f0);
    wait_reg(5, 32'd24, 80, t5_f0);
    run_cycles(30);
    check("a_f0_r3", dut.rf[3], 32'd12);
    check("a_f0_r5", dut.rf[5], 32'd24);
    check("a_f0_dmem2", dut.dmem[2], 32'd12);
    check("a_f0_seen_r5", 32'(t5_f0 > 0), 32'd1);
    check("a_stall_extra", 32'(t3_f0 - t3_f1), 32'd2);

    // Signed compare, NOR, sign extension
    for (int m = 0; m < 2; m++) begin
      prog.delete();
      prog.push_back(enc_i(6'h08, 5'd1, 5'd0, 16'hFFFF));
      prog.push_back(enc_r(6'h2A, 5'd2, 5'd1, 5'd0));
      prog.push_back(enc_i(6'h0A, 5'd3, 5'd0, 16'hFFFF));
      prog.push_back(enc_r(6'h27, 5'd4, 5'd0, 5'd0));
      prog.push_back(SELF_LOOP);
      load_program();
      start_run(m[0]);
      run_cycles(40);
      check($sformatf("b%0d_r1", m), dut.rf[1], 32'hFFFFFFFF);
      check($sformatf("b%0d_r2", m), dut.rf[2], 32'd1);
      check($sformatf("b%0d_r3", m), dut.rf[3], 32'd0);
      check($sformatf("b%0d_r4", m), dut.rf[4], 32'hFFFFFFFF);
    end

    // Taken branch flushes both shadow instructions; r0 never forwards
    for (int m = 0; m < 2; m++) begin
      prog.delete();
      prog.push_back(enc_i(6'h04, 5'd0, 5'd0, 16'd2));
      prog.push_back(enc_i(6'h08, 5'd6, 5'd0, 16'd1));
      prog.push_back(enc_i(6'h08, 5'd6, 5'd0, 16'd2));
      prog.push_back(enc_i(6'h08, 5'd8, 5'd0, 16'd3));
      prog.push_back(enc_i(6'h08, 5'd7, 5'd0, 16'd5));
      prog.push_back(enc_i(6'h08, 5'd0, 5'd0, 16'd9));
      prog.push_back(enc_r(6'h20, 5'd7, 5'd0, 5'd0));
      prog.push_back(SELF_LOOP);
      load_program();
      start_run(m[0]);
      run_cycles(40);
      check($sformatf("c%0d_r6", m), dut.rf[6], 32'd0);
      check($sformatf("c%0d_r8", m), dut.rf[8], 32'd3);
      check($sformatf("c%0d_r0", m), dut.rf[0], 32'd0);
      check($sformatf("c%0d_r7", m), dut.rf[7], 32'd0);
    end

    // Reset asserted mid-program, then a clean rerun
    prog_a();
    load_program();
    start_run(1'b1);
    run_cycles(6);
    check("mid_r1_before", dut.rf[1], 32'd5);
    RESET = 1'b0;
    #1;
    check("mid_pc_reset", dut.pc, 32'h0);
    check("mid_r1_reset", dut.rf[1], 32'h0);
    repeat (2) @(posedge CLK);
    #1;
    check("mid_r2_held", dut.rf[2], 32'h0);
    @(negedge CLK);
    RESET = 1'b1;
    cycle = 0;
    run_cycles(40);
    check("mid_r3", dut.rf[3], 32'd12);
    check("mid_r5", dut.rf[5], 32'd24);
    check("mid_dmem2", dut.dmem[2], 32'd12);

    // Random programs in both modes against the interpreter
    for (int p = 0; p < 8; p++) begin
      gen_random(20);
      for (int m = 0; m < 2; m++) begin
        load_program();
        start_run(m[0]);
        run_cycles(250);
        compare_all($sformatf("rnd%0d_f%0d", p, m));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
